// File: rtl/color_pkg.sv
// Shared types, constants and colour-acceptance helpers for the deal generator.
package color_pkg;

  localparam int COLOR_W   = 3;
  localparam int NUM_PLATS = 4;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK      = 3'b000;
  localparam color_t FALLBACK_A = 3'b001;
  localparam color_t FALLBACK_B = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BALL = 3'd1,
    ST_POS  = 3'd2,
    ST_PLAT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // A drawn colour is usable when it is neither black nor the excluded colour.
  function automatic logic color_ok(input color_t c, input color_t excl);
    return (c != BLACK) && (c != excl);
  endfunction

  function automatic color_t fallback_for(input color_t excl);
    return (excl == FALLBACK_A) ? FALLBACK_B : FALLBACK_A;
  endfunction

endpackage

// File: rtl/color_deal.sv
// Draws random bytes and assembles one deal: a ball colour plus four platform
// colours, exactly one of which matches the ball.
module color_deal
  import color_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     rnd_data,
  input  logic                           rnd_valid,
  output logic                           rnd_ready,
  input  logic                           deal_req,
  output logic                           busy,
  output logic                           deal_done,
  output logic [COLOR_W-1:0]             ball_color,
  output logic [NUM_PLATS*COLOR_W-1:0]   plat_colors,
  output logic [1:0]                     match_pos,
  output logic                           fallback
);

  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

  state_t state_r, state_next;
  logic [1:0] k_r, k_next;

  logic [3:0]                         try_r, try_next;
  color_t                             shadow_ball_r, ball_next;
  logic [1:0]                         shadow_pos_r, pos_next;
  logic [NUM_PLATS-1:0][COLOR_W-1:0]  shadow_plat_r, plat_next;
  logic                               shadow_fb_r, fb_next;

  logic [COLOR_W-1:0]             ball_color_r;
  logic [NUM_PLATS*COLOR_W-1:0]   plat_colors_r;
  logic [1:0]                     match_pos_r;
  logic                           fallback_r;
  logic                           deal_done_r;

  logic   rnd_ready_s, busy_s, xfer_s;
  color_t draw_c_s, draw_excl_s, draw_fb_s;
  logic   draw_ok_s, draw_last_s, k_last_s, load_s;
  logic   rnd_unused_s;

  // Drawn colour is tested against black in BALL and against the ball in PLAT.
  assign xfer_s       = rnd_valid & rnd_ready_s;
  assign draw_c_s     = rnd_data[2:0];
  assign draw_excl_s  = (state_r == ST_BALL) ? BLACK : shadow_ball_r;
  assign draw_ok_s    = color_ok(draw_c_s, draw_excl_s);
  assign draw_fb_s    = fallback_for(draw_excl_s);
  assign draw_last_s  = (try_r == TRY_LAST);
  assign k_last_s     = (k_r == 2'd3);
  assign load_s       = (state_next == ST_DONE);
  assign rnd_unused_s = ^rnd_data[7:3];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      k_r     <= 2'd0;
    end else begin
      state_r <= state_next;
      k_r     <= k_next;
    end
  end

  // Next-state and shadow update logic.
  always_comb begin
    state_next = state_r;
    k_next     = k_r;
    try_next   = try_r;
    ball_next  = shadow_ball_r;
    pos_next   = shadow_pos_r;
    plat_next  = shadow_plat_r;
    fb_next    = shadow_fb_r;
    case (state_r)
      ST_IDLE: begin
        if (deal_req) begin
          state_next = ST_BALL;
          try_next   = 4'd0;
          fb_next    = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BALL: begin
        if (xfer_s && draw_ok_s) begin
          ball_next  = draw_c_s;
          try_next   = 4'd0;
          state_next = ST_POS;
        end else if (xfer_s && draw_last_s) begin
          ball_next  = draw_fb_s;
          fb_next    = 1'b1;
          try_next   = 4'd0;
          state_next = ST_POS;
        end else if (xfer_s) begin
          try_next = try_r + 4'd1;
        end else begin
          state_next = ST_BALL;
        end
      end
      ST_POS: begin
        if (xfer_s) begin
          pos_next   = rnd_data[1:0];
          k_next     = 2'd0;
          state_next = ST_PLAT;
        end else begin
          state_next = ST_POS;
        end
      end
      ST_PLAT: begin
        // The matching slot is filled without consuming a byte.
        if (k_r == shadow_pos_r) begin
          plat_next[k_r] = shadow_ball_r;
          k_next         = k_r + 2'd1;
          state_next     = k_last_s ? ST_DONE : ST_PLAT;
        end else if (xfer_s && draw_ok_s) begin
          plat_next[k_r] = draw_c_s;
          try_next       = 4'd0;
          k_next         = k_r + 2'd1;
          state_next     = k_last_s ? ST_DONE : ST_PLAT;
        end else if (xfer_s && draw_last_s) begin
          plat_next[k_r] = draw_fb_s;
          fb_next        = 1'b1;
          try_next       = 4'd0;
          k_next         = k_r + 2'd1;
          state_next     = k_last_s ? ST_DONE : ST_PLAT;
        end else if (xfer_s) begin
          try_next = try_r + 4'd1;
        end else begin
          state_next = ST_PLAT;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state handshake and busy outputs.
  always_comb begin
    rnd_ready_s = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        rnd_ready_s = 1'b0;
        busy_s      = 1'b0;
      end
      ST_BALL: rnd_ready_s = 1'b1;
      ST_POS:  rnd_ready_s = 1'b1;
      ST_PLAT: rnd_ready_s = (k_r != shadow_pos_r);
      ST_DONE: rnd_ready_s = 1'b0;
      default: begin
        rnd_ready_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Shadow registers hold the deal under construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      try_r         <= 4'd0;
      shadow_ball_r <= BLACK;
      shadow_pos_r  <= 2'd0;
      shadow_plat_r <= '0;
      shadow_fb_r   <= 1'b0;
    end else begin
      try_r         <= try_next;
      shadow_ball_r <= ball_next;
      shadow_pos_r  <= pos_next;
      shadow_plat_r <= plat_next;
      shadow_fb_r   <= fb_next;
    end
  end

  // Published deal loads on entry to DONE so it is valid alongside deal_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_color_r  <= BLACK;
      plat_colors_r <= '0;
      match_pos_r   <= 2'd0;
      fallback_r    <= 1'b0;
      deal_done_r   <= 1'b0;
    end else begin
      deal_done_r <= load_s;
      if (load_s) begin
        ball_color_r  <= ball_next;
        plat_colors_r <= plat_next;
        match_pos_r   <= pos_next;
        fallback_r    <= fb_next;
      end else begin
        ball_color_r  <= ball_color_r;
        plat_colors_r <= plat_colors_r;
        match_pos_r   <= match_pos_r;
        fallback_r    <= fallback_r;
      end
    end
  end

  assign rnd_ready   = rnd_ready_s;
  assign busy        = busy_s;
  assign deal_done   = deal_done_r;
  assign ball_color  = ball_color_r;
  assign plat_colors = plat_colors_r;
  assign match_pos   = match_pos_r;
  assign fallback    = fallback_r;

endmodule
